// File: rtl/sreg_cmd_arbiter.sv
`timescale 1ns/100ps
// sreg_cmd_arbiter
//   Shares one synchro_register between two command requesters. A granted
//   command drives ZEROES or ONES for HOLD cycles, then the arbiter idles for
//   GAP cycles before the next grant. Ties are broken round-robin by default.
//   With SREG_ARB_FIXED_PRIO_EN defined, requester 0 always wins ties and
//   requester 1 may starve.
//
// Parameters
//   HOLD   cycles ZEROES/ONES stays asserted per command (>=1)
//   GAP    idle cycles after each command before the next grant (>=0)
//
// Ports
//   CLK            clock, rising edge
//   RESET          asynchronous active-high reset
//   REQ0/OP0       requester 0 request and op (0=ZEROES, 1=ONES)
//   REQ1/OP1       requester 1 request and op
//   GNT0/GNT1      1-cycle grant pulses
//   DONE0/DONE1    1-cycle pulse in the last drive cycle of a command
//   ZEROES/ONES    drive to synchro_register
//   BUSY           high while driving or in the gap
module sreg_cmd_arbiter #(
  parameter int HOLD = 4,
  parameter int GAP  = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic REQ0,
  input  logic OP0,
  input  logic REQ1,
  input  logic OP1,
  output logic GNT0,
  output logic GNT1,
  output logic DONE0,
  output logic DONE1,
  output logic ZEROES,
  output logic ONES,
  output logic BUSY
);

  localparam int CW       = $clog2(HOLD + GAP + 1);
  localparam int GAP_LD_I = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_LD_I);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          op, op_n;
  logic          owner, owner_n;
  logic          try_grant;
  logic          pick1;
  logic          gnt0_n, gnt1_n;

`ifdef SREG_ARB_FIXED_PRIO_EN
  assign pick1 = REQ1 & ~REQ0;
`else
  logic rr_ptr, rr_ptr_n;
  // On a tie the requester named by rr_ptr wins.
  assign pick1 = REQ1 & (~REQ0 | rr_ptr);
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    op_n      = op;
    owner_n   = owner;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    try_grant = 1'b0;
`ifndef SREG_ARB_FIXED_PRIO_EN
    rr_ptr_n  = rr_ptr;
`endif
    case (state)
      S_IDLE: try_grant = 1'b1;
      S_DRIVE: begin
        if (cnt == '0) begin
          if (GAP > 0) begin
            state_n = S_GAP;
            cnt_n   = GAP_LD;
          end else begin
            // No gap: a new command may start at this same edge.
            state_n   = S_IDLE;
            try_grant = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_n   = S_IDLE;
          try_grant = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (try_grant && (REQ0 || REQ1)) begin
      state_n = S_DRIVE;
      cnt_n   = HOLD_LD;
      owner_n = pick1;
      op_n    = pick1 ? OP1 : OP0;
      gnt0_n  = ~pick1;
      gnt1_n  = pick1;
`ifndef SREG_ARB_FIXED_PRIO_EN
      rr_ptr_n = ~pick1;
`endif
    end
  end

  // State register; outputs are registered from the next-state decode so
  // every output is a flop that clears asynchronously with RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= 1'b0;
      owner  <= 1'b0;
      GNT0   <= 1'b0;
      GNT1   <= 1'b0;
      DONE0  <= 1'b0;
      DONE1  <= 1'b0;
      ZEROES <= 1'b0;
      ONES   <= 1'b0;
      BUSY   <= 1'b0;
`ifndef SREG_ARB_FIXED_PRIO_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op     <= op_n;
      owner  <= owner_n;
      GNT0   <= gnt0_n;
      GNT1   <= gnt1_n;
      DONE0  <= (state_n == S_DRIVE) && (cnt_n == '0) && !owner_n;
      DONE1  <= (state_n == S_DRIVE) && (cnt_n == '0) && owner_n;
      ZEROES <= (state_n == S_DRIVE) && !op_n;
      ONES   <= (state_n == S_DRIVE) && op_n;
      BUSY   <= (state_n != S_IDLE);
`ifndef SREG_ARB_FIXED_PRIO_EN
      rr_ptr <= rr_ptr_n;
`endif
    end
  end

endmodule
